stopwatch_ctrl: RTL

Run/pause/lap/clear sequencer for the stopwatch time counter. Turns two raw push-buttons into the counter's run enable and synchronous clear, and latches a lap snapshot. Drives the display values, muxing between the live count and the frozen lap value. Sits between the board buttons and the counter; its display outputs feed the 7-segment formatter.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/button_debouncer.sv | 44 ++++
 rtl/stopwatch_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch encodings and time field widths.
// Used by the controller, the counter and the display formatter.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LAP   = 2'b11;

  localparam int HOURS_W = 4;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int MS_W    = 10;

  typedef struct packed {
    logic [HOURS_W-1:0] hours;
    logic [MIN_W-1:0]   minutes;
    logic [SEC_W-1:0]   seconds;
    logic [MS_W-1:0]    ms;
  } time_t;

endpackage

// File: rtl/button_debouncer.sv
// Raw button to one-cycle press pulse: 2-FF sync,
// stability counter, rising-edge detect on the accepted level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that differ from the accepted level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer with lap snapshot
// and registered display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_start_stop,
  input  logic               btn_lap_reset,
  input  logic [HOURS_W-1:0] live_hours,
  input  logic [MIN_W-1:0]   live_minutes,
  input  logic [SEC_W-1:0]   live_seconds,
  input  logic [MS_W-1:0]    live_ms,
  output logic               st_signal,
  output logic               clr,
  output logic [HOURS_W-1:0] disp_hours,
  output logic [MIN_W-1:0]   disp_minutes,
  output logic [SEC_W-1:0]   disp_seconds,
  output logic [MS_W-1:0]    disp_ms,
  output logic               lap_valid,
  output logic [1:0]         state
);

  logic  press_a;
  logic  press_b;
  logic  pb;
  logic  [1:0] state_d;
  logic  clr_d;
  logic  cap;
  logic  zero;
  time_t live;
  time_t snap;
  time_t disp;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_a (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_start_stop),
    .press(press_a)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_b (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_lap_reset),
    .press(press_b)
  );

  assign live = '{
    hours:   live_hours,
    minutes: live_minutes,
    seconds: live_seconds,
    ms:      live_ms
  };

  // start/stop has priority; a simultaneous lap press is dropped
  assign pb = press_b & ~press_a;

  always_comb begin
    state_d = state;
    clr_d   = 1'b0;
    cap     = 1'b0;
    zero    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (press_a) state_d = ST_RUN;
        else if (pb) clr_d = 1'b1;
      end
      ST_RUN: begin
        if (press_a) begin
          state_d = ST_PAUSE;
        end else if (pb) begin
          state_d = ST_LAP;
          cap     = 1'b1;
        end
      end
      ST_LAP: begin
        if (press_a) state_d = ST_PAUSE;
        else if (pb) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (press_a) begin
          state_d = ST_RUN;
        end else if (pb) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
          zero    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      clr       <= 1'b0;
      st_signal <= 1'b0;
      lap_valid <= 1'b0;
      snap      <= '0;
      disp      <= '0;
    end else begin
      state     <= state_d;
      clr       <= clr_d;
      st_signal <= (state_d == ST_RUN) || (state_d == ST_LAP);
      lap_valid <= (state_d == ST_LAP);
      if (cap) snap <= live;
      else if (zero) snap <= '0;
      // entering LAP shows the value being captured this edge
      if ((state == ST_LAP) && (state_d == ST_LAP)) disp <= snap;
      else disp <= live;
    end
  end

  assign disp_hours   = disp.hours;
  assign disp_minutes = disp.minutes;
  assign disp_seconds = disp.seconds;
  assign disp_ms      = disp.ms;

endmodule
